// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and scan-code digit lookup for the
// PS/2 numeric entry block.
package ps2_pkg;

  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] KEY_BKSP   = 8'h66;
  localparam logic [7:0] KEY_ESC    = 8'h76;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;

  localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
  localparam logic [1:0] ST_ENTRY_ENC = 2'd1;
  localparam logic [1:0] ST_FULL_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = ST_EMPTY_ENC,
    ST_ENTRY = ST_ENTRY_ENC,
    ST_FULL  = ST_FULL_ENC
  } state_t;

  // Returns {hit, value}; hit=0 means the make code is not a digit key.
  function automatic logic [4:0] map_digit(input logic [7:0] make,
                                           input logic       keypad_en);
    logic [4:0] r;
    r = 5'h00;
    case (make)
      8'h45: r = 5'h10;
      8'h16: r = 5'h11;
      8'h1E: r = 5'h12;
      8'h26: r = 5'h13;
      8'h25: r = 5'h14;
      8'h2E: r = 5'h15;
      8'h36: r = 5'h16;
      8'h3D: r = 5'h17;
      8'h3E: r = 5'h18;
      8'h46: r = 5'h19;
      default: r = 5'h00;
    endcase
    if (!r[4] && keypad_en) begin
      case (make)
        8'h70: r = 5'h10;
        8'h69: r = 5'h11;
        8'h72: r = 5'h12;
        8'h7A: r = 5'h13;
        8'h6B: r = 5'h14;
        8'h73: r = 5'h15;
        8'h74: r = 5'h16;
        8'h6C: r = 5'h17;
        8'h75: r = 5'h18;
        8'h7D: r = 5'h19;
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_event_detect.sv
// Turns the receiver's level-style code-available flag into a single-cycle
// event, qualified so only break codes (F0xx) get through.
module ps2_event_detect
  import ps2_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_code,
  input  logic        i_status,
  output logic        o_event,
  output logic [7:0]  o_make
);

  logic r_status_d;

  // Previous flag value for rising-edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) r_status_d <= 1'b0;
    else       r_status_d <= i_status;
  end

  assign o_event = i_status & ~r_status_d & (i_code[15:8] == BRK_PREFIX);
  assign o_make  = i_code[7:0];

endmodule

// File: rtl/ps2_num_entry.sv
// Multi-digit decimal entry from PS/2 break codes: packed-BCD buffer with
// backspace, clear and commit. All outputs are registered.
module ps2_num_entry
  import ps2_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int KEYPAD_EN = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [15:0]                  i_code,
  input  logic                         i_status,
  output logic [4*DIGITS-1:0]          o_buf,
  output logic [$clog2(DIGITS+1)-1:0]  o_count,
  output logic                         o_digit,
  output logic [3:0]                   o_num,
  output logic                         o_valid,
  output logic [4*DIGITS-1:0]          o_value,
  output logic                         o_error
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic          w_event;
  logic [7:0]    w_make;
  logic [4:0]    w_map;

  state_t        r_state, w_state;
  logic [BW-1:0] r_buf,   w_buf;
  logic [CW-1:0] r_count, w_count;
  logic [3:0]    r_num,   w_num;
  logic [BW-1:0] r_value, w_value;
  logic          r_digit, w_digit;
  logic          r_valid, w_valid;
  logic          r_error, w_error;

  ps2_event_detect u_evt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_code   (i_code),
    .i_status (i_status),
    .o_event  (w_event),
    .o_make   (w_make)
  );

  assign w_map = map_digit(w_make, KEYPAD_EN != 0);

  // State, buffer and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_buf   <= '0;
      r_count <= '0;
      r_num   <= '0;
      r_value <= '0;
      r_digit <= 1'b0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state;
      r_buf   <= w_buf;
      r_count <= w_count;
      r_num   <= w_num;
      r_value <= w_value;
      r_digit <= w_digit;
      r_valid <= w_valid;
      r_error <= w_error;
    end
  end

  // Next-state and next-output decode; one event per cycle at most, so the
  // pulses are mutually exclusive by construction
  always_comb begin
    w_state = r_state;
    w_buf   = r_buf;
    w_count = r_count;
    w_num   = r_num;
    w_value = r_value;
    w_digit = 1'b0;
    w_valid = 1'b0;
    w_error = 1'b0;
    if (w_event) begin
      if (w_map[4]) begin
        if (r_state == ST_FULL) begin
          // Overflow: buffer and last digit stay as they are
          w_error = 1'b1;
        end else begin
          // Shift form works for DIGITS=1 where a concat slice would not
          w_buf   = (r_buf << 4) | BW'(w_map[3:0]);
          w_count = r_count + 1'b1;
          w_digit = 1'b1;
          w_num   = w_map[3:0];
          w_state = (w_count == CW'(DIGITS)) ? ST_FULL : ST_ENTRY;
        end
      end else begin
        case (w_make)
          KEY_BKSP: begin
            if (r_state != ST_EMPTY) begin
              w_buf   = r_buf >> 4;
              w_count = r_count - 1'b1;
              w_state = (w_count == '0) ? ST_EMPTY : ST_ENTRY;
            end
          end
          KEY_ESC: begin
            w_buf   = '0;
            w_count = '0;
            w_state = ST_EMPTY;
          end
          KEY_ENTER: begin
            if (r_state == ST_EMPTY) begin
              w_error = 1'b1;
            end else begin
              w_value = r_buf;
              w_valid = 1'b1;
              w_buf   = '0;
              w_count = '0;
              w_state = ST_EMPTY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_buf   = r_buf;
  assign o_count = r_count;
  assign o_digit = r_digit;
  assign o_num   = r_num;
  assign o_valid = r_valid;
  assign o_value = r_value;
  assign o_error = r_error;

endmodule

// File: tb/tb_ps2_num_entry.sv
// Bench for ps2_num_entry: two instances (4 digits with keypad, 3 digits
// without) driven in lockstep and compared every cycle to a digit-list model.
module tb_ps2_num_entry;
  import ps2_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] code = 16'h0000;
  logic        status = 1'b0;

  logic [15:0] a_buf, a_value;
  logic [2:0]  a_count;
  logic [3:0]  a_num;
  logic        a_digit, a_valid, a_error;
  logic [11:0] b_buf, b_value;
  logic [1:0]  b_count;
  logic [3:0]  b_num;
  logic        b_digit, b_valid, b_error;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ps2_num_entry #(.DIGITS(4), .KEYPAD_EN(1)) ua (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_status(status),
    .o_buf(a_buf), .o_count(a_count), .o_digit(a_digit), .o_num(a_num),
    .o_valid(a_valid), .o_value(a_value), .o_error(a_error));

  ps2_num_entry #(.DIGITS(3), .KEYPAD_EN(0)) ub (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_status(status),
    .o_buf(b_buf), .o_count(b_count), .o_digit(b_digit), .o_num(b_num),
    .o_valid(b_valid), .o_value(b_value), .o_error(b_error));

  // Reference model: per instance, the list of entered digits (oldest first)
  logic [7:0] top_tbl [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] kp_tbl  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                               8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  int          mdig [2] = '{4, 3};
  bit          mkp  [2] = '{1'b1, 1'b0};
  int          mcnt [2];
  int          ment [2][8];
  logic [31:0] mval [2];
  logic [3:0]  mnum [2];
  bit          mpd [2], mpv [2], mpe [2];
  bit          mprev;

  function automatic int lookup(input logic [7:0] mk, input bit kpe);
    for (int d = 0; d < 10; d++) begin
      if (top_tbl[d] == mk) return d;
      if (kpe && kp_tbl[d] == mk) return d;
    end
    return -1;
  endfunction

  function automatic logic [31:0] compose(input int k);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < mcnt[k]; i++)
      r = r | (32'(ment[k][i]) << (4 * (mcnt[k] - 1 - i)));
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mval[k] = 0; mnum[k] = 0;
      mpd[k] = 0; mpv[k] = 0; mpe[k] = 0;
    end
    mprev = 0;
  endtask

  task automatic model_event(input logic [7:0] mk);
    int d;
    for (int k = 0; k < 2; k++) begin
      d = lookup(mk, mkp[k]);
      if (d >= 0) begin
        if (mcnt[k] < mdig[k]) begin
          ment[k][mcnt[k]] = d; mcnt[k]++; mpd[k] = 1; mnum[k] = 4'(d);
        end else mpe[k] = 1;
      end else if (mk == 8'h66) begin
        if (mcnt[k] > 0) mcnt[k]--;
      end else if (mk == 8'h76) begin
        mcnt[k] = 0;
      end else if (mk == 8'h5A) begin
        if (mcnt[k] > 0) begin
          mval[k] = compose(k); mpv[k] = 1; mcnt[k] = 0;
        end else mpe[k] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.buf",   32'(a_buf),   compose(0));
    chk("a.count", 32'(a_count), 32'(mcnt[0]));
    chk("a.digit", 32'(a_digit), 32'(mpd[0]));
    chk("a.num",   32'(a_num),   32'(mnum[0]));
    chk("a.valid", 32'(a_valid), 32'(mpv[0]));
    chk("a.value", 32'(a_value), mval[0]);
    chk("a.error", 32'(a_error), 32'(mpe[0]));
    chk("b.buf",   32'(b_buf),   compose(1));
    chk("b.count", 32'(b_count), 32'(mcnt[1]));
    chk("b.digit", 32'(b_digit), 32'(mpd[1]));
    chk("b.num",   32'(b_num),   32'(mnum[1]));
    chk("b.valid", 32'(b_valid), 32'(mpv[1]));
    chk("b.value", 32'(b_value), mval[1]);
    chk("b.error", 32'(b_error), 32'(mpe[1]));
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising
  task automatic cycle(input logic r, input logic [15:0] c, input logic s);
    @(negedge clk);
    rst = r; code = c; status = s;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin mpd[k] = 0; mpv[k] = 0; mpe[k] = 0; end
    if (r) model_clear();
    else begin
      if (s && !mprev && c[15:8] == 8'hF0) model_event(c[7:0]);
      mprev = s;
    end
    check_all();
  endtask

  task automatic ev(input logic [15:0] c);
    cycle(1'b0, c, 1'b1);
    cycle(1'b0, c, 1'b0);
  endtask

  initial begin
    logic [15:0] rc;
    logic        rs;
    model_clear();
    // Reset state
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0);
    // Enter 1,2,3 and commit
    ev(16'hF016); ev(16'hF01E); ev(16'hF026); ev(16'hF05A);
    // Overflow on the fifth digit
    ev(16'hF045); ev(16'hF046); ev(16'hF03E); ev(16'hF03D); ev(16'hF036);
    // Backspace handling and commit on empty
    ev(16'hF076);
    ev(16'hF02E); ev(16'hF025); ev(16'hF066); ev(16'hF026);
    ev(16'hF066); ev(16'hF066); ev(16'hF066); ev(16'hF05A);
    // Held status gives one event; make code and unknown break ignored
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'hF016, 1'b1);
    cycle(1'b0, 16'hF016, 1'b0);
    ev(16'h0016); ev(16'hF0E0);
    ev(16'hF076);
    // Keypad digits (instance b has the keypad disabled)
    ev(16'hF069); ev(16'hF07D); ev(16'hF05A);
    // Reset mid-entry, then Esc in empty
    ev(16'hF016); ev(16'hF01E);
    cycle(1'b1, 16'h0000, 1'b0);
    ev(16'hF076);
    // Randomized traffic
    rc = 16'hF016;
    rs = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        cycle(1'b1, rc, 1'b0);
        rs = 1'b0;
        continue;
      end
      if (!rs) begin
        case ($urandom_range(0, 11))
          0, 1, 2, 3: rc = {8'hF0, top_tbl[$urandom_range(0, 9)]};
          4, 5:       rc = {8'hF0, kp_tbl[$urandom_range(0, 9)]};
          6, 7:       rc = 16'hF066;
          8:          rc = 16'hF076;
          9:          rc = 16'hF05A;
          10:         rc = {8'hF0, 8'($urandom)};
          default:    rc = {8'($urandom), top_tbl[$urandom_range(0, 9)]};
        endcase
      end
      rs = ($urandom_range(0, 2) != 0) ? ~rs : rs;
      cycle(1'b0, rc, rs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
